// File: rtl/fighter_ctrl.sv
// Frame-stepped fighter controller: synchronized and debounced buttons drive a
// walk / attack state machine that moves a 40-px sprite along X.
module fighter_ctrl #(
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 599,
   parameter int X_INIT     = 0,
   parameter int WALK_SPD   = 2,
   parameter int DEB_FRAMES = 3,
   parameter int STARTUP_F  = 4,
   parameter int ACTIVE_F   = 3,
   parameter int RECOVER_F  = 8
) (
   input  logic       clk_pix,
   input  logic       sim_rst,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_attack,
   output logic [9:0] pos_x,
   output logic [2:0] fstate,
   output logic       hit_active,
   output logic [3:0] phase_cnt
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WALK_L  = 3'd1;
   localparam logic [2:0] ST_WALK_R  = 3'd2;
   localparam logic [2:0] ST_STARTUP = 3'd3;
   localparam logic [2:0] ST_ACTIVE  = 3'd4;
   localparam logic [2:0] ST_RECOVER = 3'd5;

   localparam int CW = (DEB_FRAMES < 2) ? 1 : $clog2(DEB_FRAMES + 1);

   // Button vectors: bit 0 left, bit 1 right, bit 2 attack.
   logic [2:0]    sync_a, sync_b;
   logic [2:0]    clean, clean_nxt;
   logic [CW-1:0] deb_cnt     [3];
   logic [CW-1:0] deb_cnt_nxt [3];
   logic          atk_pend, atk_rise;
   logic          walk_l, walk_r;

   logic [2:0]  state_nxt;
   logic [9:0]  pos_nxt, pos_dec, pos_inc;
   logic [3:0]  phase_nxt;
   logic [10:0] pos_w, pos_sum;
   logic        dec_ok;

   always_ff @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {btn_attack, btn_right, btn_left};
         sync_b <= sync_a;
      end
   end

   // A sample that disagrees with the clean level counts up; any agreeing sample clears.
   always_comb begin
      clean_nxt = clean;
      for (int i = 0; i < 3; i++) begin
         deb_cnt_nxt[i] = deb_cnt[i];
         if (frame_tick) begin
            if (sync_b[i] != clean[i]) begin
               if (int'(deb_cnt[i]) + 1 >= DEB_FRAMES) begin
                  clean_nxt[i]   = sync_b[i];
                  deb_cnt_nxt[i] = '0;
               end else begin
                  deb_cnt_nxt[i] = deb_cnt[i] + CW'(1);
               end
            end else begin
               deb_cnt_nxt[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) begin
         clean <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         clean <= clean_nxt;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= deb_cnt_nxt[i];
      end
   end

   // Movement follows the level accepted on this very tick; attack waits one tick.
   assign atk_rise = clean_nxt[2] & ~clean[2];
   assign walk_l   = clean_nxt[0] & ~clean_nxt[1];
   assign walk_r   = clean_nxt[1] & ~clean_nxt[0];

   assign pos_w   = {1'b0, pos_x};
   assign pos_sum = pos_w + 11'(WALK_SPD);
   assign dec_ok  = pos_w >= (11'(X_MIN) + 11'(WALK_SPD));
   assign pos_dec = dec_ok ? (pos_x - 10'(WALK_SPD)) : 10'(X_MIN);
   assign pos_inc = (pos_sum > 11'(X_MAX)) ? 10'(X_MAX) : (pos_x + 10'(WALK_SPD));

   always_comb begin
      state_nxt = fstate;
      pos_nxt   = pos_x;
      phase_nxt = phase_cnt;
      if (frame_tick) begin
         case (fstate)
            ST_IDLE, ST_WALK_L, ST_WALK_R: begin
               phase_nxt = '0;
               if (atk_pend) begin
                  state_nxt = ST_STARTUP;
               end else if (walk_l) begin
                  state_nxt = ST_WALK_L;
                  pos_nxt   = pos_dec;
               end else if (walk_r) begin
                  state_nxt = ST_WALK_R;
                  pos_nxt   = pos_inc;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_STARTUP: begin
               if (phase_cnt == 4'(STARTUP_F - 1)) begin
                  state_nxt = ST_ACTIVE;
                  phase_nxt = '0;
               end else begin
                  phase_nxt = phase_cnt + 4'd1;
               end
            end
            ST_ACTIVE: begin
               if (phase_cnt == 4'(ACTIVE_F - 1)) begin
                  state_nxt = ST_RECOVER;
                  phase_nxt = '0;
               end else begin
                  phase_nxt = phase_cnt + 4'd1;
               end
            end
            ST_RECOVER: begin
               if (phase_cnt == 4'(RECOVER_F - 1)) begin
                  state_nxt = ST_IDLE;
                  phase_nxt = '0;
               end else begin
                  phase_nxt = phase_cnt + 4'd1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               phase_nxt = '0;
            end
         endcase
      end
   end

   // Each tick replaces the pending press, so a press seen mid-attack is dropped.
   always_ff @(posedge clk_pix or posedge sim_rst) begin
      if (sim_rst) begin
         fstate     <= ST_IDLE;
         pos_x      <= 10'(X_INIT);
         phase_cnt  <= '0;
         hit_active <= 1'b0;
         atk_pend   <= 1'b0;
      end else begin
         fstate     <= state_nxt;
         pos_x      <= pos_nxt;
         phase_cnt  <= phase_nxt;
         hit_active <= (state_nxt == ST_ACTIVE);
         if (frame_tick) atk_pend <= atk_rise;
      end
   end

endmodule
